// File: rtl/wb_commit_mlane.sv
// Multi-lane writeback stage: registered MEM/WB boundary, load alignment,
// register-file write ports and an in-order trace FIFO feeding the debug port.
module wb_commit_mlane #(
  parameter int LANES       = 2,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES-1:0]      in_valid,
  input  logic [32*LANES-1:0]   in_pc,
  input  logic [8*LANES-1:0]    in_aluop,
  input  logic [LANES-1:0]      in_wen,
  input  logic [5*LANES-1:0]    in_waddr,
  input  logic [32*LANES-1:0]   in_alu_data,
  input  logic [32*LANES-1:0]   in_rt_data,
  input  logic [32*LANES-1:0]   in_mem_rdata,
  input  logic [32*LANES-1:0]   in_mem_addr,
  input  logic [LANES-1:0]      in_mem_to_reg,
  output logic                  stall_o,
  output logic [LANES-1:0]      rf_wen,
  output logic [5*LANES-1:0]    rf_waddr,
  output logic [32*LANES-1:0]   rf_wdata,
  output logic [31:0]           debug_pc,
  output logic [3:0]            debug_regfile_wen,
  output logic [4:0]            debug_regfile_waddr,
  output logic [31:0]           debug_regfile_wdata
);

  localparam logic [7:0] ALUOP_LB  = 8'h20;
  localparam logic [7:0] ALUOP_LH  = 8'h21;
  localparam logic [7:0] ALUOP_LWL = 8'h22;
  localparam logic [7:0] ALUOP_LW  = 8'h23;
  localparam logic [7:0] ALUOP_LBU = 8'h24;
  localparam logic [7:0] ALUOP_LHU = 8'h25;
  localparam logic [7:0] ALUOP_LWR = 8'h26;

  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } trace_t;

  logic [LANES-1:0]    wbValid_q, wbWen_q, wbMemToReg_q;
  logic [32*LANES-1:0] wbPc_q, wbAlu_q, wbRt_q, wbRdata_q;
  logic [8*LANES-1:0]  wbAluop_q;
  logic [5*LANES-1:0]  wbWaddr_q;
  logic [2*LANES-1:0]  wbAddrLo_q;

  logic [LANES-1:0]    commit;
  logic [32*LANES-1:0] wdata;

  trace_t              traceMem [TRACE_DEPTH];
  trace_t              head;
  logic [PTR_W-1:0]    wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]    count_q;
  logic [PTR_W-1:0]    slot [LANES];
  logic [CNT_W-1:0]    pushCnt;
  logic                pop;
  logic                unusedAddrBits;

  // Only the byte offset of the load address matters for alignment.
  assign unusedAddrBits = ^in_mem_addr;

  function automatic logic [31:0] alignLoad(input logic [7:0] op, input logic [1:0] a,
                                            input logic [31:0] rd, input logic [31:0] rt);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*a +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (op)
      ALUOP_LB:  return {{24{b[7]}}, b};
      ALUOP_LBU: return {24'h0, b};
      ALUOP_LH:  return {{16{h[15]}}, h};
      ALUOP_LHU: return {16'h0, h};
      ALUOP_LW:  return rd;
      ALUOP_LWL: begin
        case (a)
          2'd0:    return {rd[7:0], rt[23:0]};
          2'd1:    return {rd[15:0], rt[15:0]};
          2'd2:    return {rd[23:0], rt[7:0]};
          default: return rd;
        endcase
      end
      ALUOP_LWR: begin
        case (a)
          2'd0:    return rd;
          2'd1:    return {rt[31:24], rd[31:8]};
          2'd2:    return {rt[31:16], rd[31:16]};
          default: return {rt[31:8], rd[31:24]};
        endcase
      end
      default:   return 32'h0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wbValid_q    <= '0;
      wbWen_q      <= '0;
      wbMemToReg_q <= '0;
      wbPc_q       <= '0;
      wbAlu_q      <= '0;
      wbRt_q       <= '0;
      wbRdata_q    <= '0;
      wbAluop_q    <= '0;
      wbWaddr_q    <= '0;
      wbAddrLo_q   <= '0;
    end else if (!stall_o) begin
      wbValid_q    <= in_valid;
      wbWen_q      <= in_wen;
      wbMemToReg_q <= in_mem_to_reg;
      wbPc_q       <= in_pc;
      wbAlu_q      <= in_alu_data;
      wbRt_q       <= in_rt_data;
      wbRdata_q    <= in_mem_rdata;
      wbAluop_q    <= in_aluop;
      wbWaddr_q    <= in_waddr;
      for (int i = 0; i < LANES; i++) begin
        wbAddrLo_q[2*i +: 2] <= in_mem_addr[32*i +: 2];
      end
    end
  end

  // A held entry commits only in the cycle it leaves WB, so stall gates the write.
  always_comb begin
    commit = '0;
    wdata  = '0;
    for (int i = 0; i < LANES; i++) begin
      commit[i] = wbValid_q[i] & wbWen_q[i] & ~stall_o;
      wdata[32*i +: 32] = wbMemToReg_q[i]
        ? alignLoad(wbAluop_q[8*i +: 8], wbAddrLo_q[2*i +: 2], wbRdata_q[32*i +: 32], wbRt_q[32*i +: 32])
        : wbAlu_q[32*i +: 32];
    end
  end

  assign rf_wen   = commit;
  assign rf_waddr = wbWaddr_q;
  assign rf_wdata = wdata;

  // Committing lanes take consecutive FIFO slots, older lane first.
  always_comb begin
    pushCnt = '0;
    for (int i = 0; i < LANES; i++) begin
      slot[i] = wrPtr_q + pushCnt[PTR_W-1:0];
      pushCnt = pushCnt + CNT_W'(commit[i]);
    end
  end

  assign pop     = (count_q != '0);
  assign head    = traceMem[rdPtr_q];
  assign stall_o = (CNT_W'(TRACE_DEPTH) - count_q) < CNT_W'(LANES);

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (commit[i]) begin
        traceMem[slot[i]] <= {wbPc_q[32*i +: 32], wbWaddr_q[5*i +: 5], wdata[32*i +: 32]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_q + pushCnt[PTR_W-1:0];
      rdPtr_q <= rdPtr_q + PTR_W'(pop);
      count_q <= count_q + pushCnt - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      debug_pc            <= '0;
      debug_regfile_wen   <= '0;
      debug_regfile_waddr <= '0;
      debug_regfile_wdata <= '0;
    end else if (pop) begin
      debug_pc            <= head.pc;
      debug_regfile_wen   <= 4'hf;
      debug_regfile_waddr <= head.waddr;
      debug_regfile_wdata <= head.wdata;
    end else begin
      debug_regfile_wen   <= '0;
    end
  end

endmodule
